// File: rtl/dtc_share_arb_pkg.sv
// dtc_share_pkg: shared FSM state type, default sizes and id-width helper for the classifier share arbiter
package dtc_share_pkg;
  typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_DW = 8;
  localparam int DEF_OW = 8;
  function automatic int id_width(input int n);
    return n < 2 ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/dtc_share_arb_if.sv
// dtc_share_arb_if: requester and response channels between front ends, arbiter and result sink
interface dtc_share_arb_if import dtc_share_pkg::*; #(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DW = DEF_DW,
  parameter int OW = DEF_OW,
  localparam int IDW = id_width(NUM_REQ)
) ();
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ*DW-1:0] req_data;
  logic rsp_valid;
  logic rsp_ready;
  logic [OW-1:0] rsp_data;
  logic [IDW-1:0] rsp_id;
  modport master (output req_valid, req_data, rsp_ready, input req_ready, rsp_valid, rsp_data, rsp_id);
  modport slave (input req_valid, req_data, rsp_ready, output req_ready, rsp_valid, rsp_data, rsp_id);
endinterface

// File: rtl/dtc_share_arb_rr_pick.sv
// dtc_rr_pick: combinational round-robin picker, searching from ptr+1 upward modulo N
module dtc_rr_pick #(
  parameter int N = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  // scanning from the far end lets the nearest requester after ptr overwrite the others
  always_comb begin
    int j;
    j = 0;
    idx = '0;
    for (int k = N; k >= 1; k--) begin
      j = (int'(ptr) + k) % N;
      if (req[j]) idx = IW'(j);
    end
    any = |req;
    gnt = any ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/dtc_share_arb.sv
// dtc_share_arb: round-robin sharing of one combinational decision-tree classifier among NUM_REQ requesters
module dtc_share_arb import dtc_share_pkg::*; #(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DW = DEF_DW,
  parameter int OW = DEF_OW,
  parameter int EVAL_CYCLES = 1,
  localparam int IDW = id_width(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  dtc_share_arb_if.slave       bus,
  output logic [DW-1:0]        cls_inp,
  input  logic [OW-1:0]        cls_outp,
  output logic                 busy
);
  localparam int CW = id_width(EVAL_CYCLES);
  state_t state_q, state_d;
  logic [IDW-1:0] rr_ptr, id_q, win_idx;
  logic [NUM_REQ-1:0] win_gnt;
  logic win_any, accept, capture, done;
  logic [CW-1:0] cnt;
  dtc_rr_pick #(.N(NUM_REQ), .IW(IDW)) u_pick (
    .req(bus.req_valid),
    .ptr(rr_ptr),
    .gnt(win_gnt),
    .idx(win_idx),
    .any(win_any)
  );
  always_ff @(posedge clk) state_q <= rst ? IDLE : state_d;
  always_comb begin
    accept = state_q == IDLE && win_any;
    capture = state_q == EVAL && cnt == '0;
    done = state_q == RESP && bus.rsp_ready;
    state_d = accept ? EVAL : capture ? RESP : done ? IDLE : state_q;
  end
  always_comb begin
    bus.req_ready = state_q == IDLE ? win_gnt : '0;
    bus.rsp_valid = state_q == RESP;
    busy = state_q != IDLE;
  end
  // the core is sampled only after cls_inp has been stable for EVAL_CYCLES cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= IDW'(NUM_REQ - 1);
      id_q <= '0;
      cnt <= '0;
      cls_inp <= '0;
      bus.rsp_data <= '0;
      bus.rsp_id <= '0;
    end else begin
      if (accept) begin
        cls_inp <= bus.req_data[win_idx*DW +: DW];
        id_q <= win_idx;
        rr_ptr <= win_idx;
        cnt <= CW'(EVAL_CYCLES - 1);
      end
      if (state_q == EVAL && !capture) cnt <= cnt - 1'b1;
      if (capture) begin
        bus.rsp_data <= cls_outp;
        bus.rsp_id <= id_q;
      end
    end
  end
endmodule
